artemis_rst_sequencer: RTL and testbench

//  Consumer side of the clock generator's lock interface: watches PLL 'locked',

---
 rtl/artemis_rst_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_artemis_rst_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/artemis_rst_sequencer.sv
// -----------------------------------------------------------------------------
// artemis_rst_sequencer
//
// Purpose:
//   Consumer side of the clock generator's lock interface. Runs on the
//   free-running board clock (never on a PLL output), pulses the PLL reset,
//   waits for a stable lock and only then releases the system reset.
//   A PLL that fails to lock within LOCK_TIMEOUT cycles is re-pulsed; a lock
//   drop while running triggers a full re-sequence. Both kinds of event are
//   tallied in saturating counters.
//
// Ports:
//   clk              in   1          free-running board clock
//   rst              in   1          synchronous, active-high reset
//   pll_locked       in   1          PLL lock, asynchronous to clk
//   clear_counts     in   1          synchronous clear of both event counters
//   pll_rst          out  1          reset to the PLL, active-high
//   sys_rst          out  1          system reset, active-high
//   ready            out  1          high only while in RUN
//   state            out  2          0 PLL_RESET, 1 WAIT_LOCK, 2 HOLD, 3 RUN
//   timeout_count    out  CNT_WIDTH  lock-timeout events, saturating
//   lock_loss_count  out  CNT_WIDTH  lock drops while in RUN, saturating
//
// There is no valid/ready handshake on this block: 'ready' is a level status
// flag meaning "clocks are good and sys_rst is released", nothing more.
// -----------------------------------------------------------------------------
module artemis_rst_sequencer #(
   parameter int unsigned PLL_RST_CYCLES = 16,
   parameter int unsigned LOCK_TIMEOUT   = 100000,
   parameter int unsigned HOLD_CYCLES    = 256,
   parameter int unsigned CNT_WIDTH      = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 pll_locked,
   input  logic                 clear_counts,
   output logic                 pll_rst,
   output logic                 sys_rst,
   output logic                 ready,
   output logic [1:0]           state,
   output logic [CNT_WIDTH-1:0] timeout_count,
   output logic [CNT_WIDTH-1:0] lock_loss_count
);

   // One shared timer, sized for the longest of the three intervals.
   localparam int unsigned MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
   localparam int unsigned MAX_CYC = (MAX_AB > HOLD_CYCLES) ? MAX_AB : HOLD_CYCLES;
   localparam int unsigned TW      = $clog2(MAX_CYC) + 1;

   localparam logic [TW-1:0] PLL_LAST  = TW'(PLL_RST_CYCLES - 1);
   localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_TIMEOUT - 1);
   localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

   typedef enum logic [1:0] {
      ST_PLL_RESET = 2'd0,
      ST_WAIT_LOCK = 2'd1,
      ST_HOLD      = 2'd2,
      ST_RUN       = 2'd3
   } state_e;

   state_e               state_q, state_d;
   logic [TW-1:0]        timer_q, timer_d;
   logic                 sync1_q, locked_s_q;
   logic                 pll_rst_q, sys_rst_q, ready_q;
   logic [CNT_WIDTH-1:0] timeout_cnt_q, timeout_cnt_d;
   logic [CNT_WIDTH-1:0] loss_cnt_q, loss_cnt_d;
   logic                 timeout_evt, loss_evt;

   // --------------------------------------------------------------------------
   // Two-flop synchronizer for the asynchronous lock signal. The FSM only ever
   // looks at locked_s_q.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q    <= 1'b0;
         locked_s_q <= 1'b0;
      end else begin
         sync1_q    <= pll_locked;
         locked_s_q <= sync1_q;
      end
   end

   // --------------------------------------------------------------------------
   // State register, timer, counters and registered output decodes.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_PLL_RESET;
         timer_q       <= '0;
         pll_rst_q     <= 1'b1;
         sys_rst_q     <= 1'b1;
         ready_q       <= 1'b0;
         timeout_cnt_q <= '0;
         loss_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         // Decoded from the next state so the outputs switch on the same edge
         // as the state and come straight from flops.
         pll_rst_q     <= (state_d == ST_PLL_RESET);
         sys_rst_q     <= (state_d != ST_RUN);
         ready_q       <= (state_d == ST_RUN);
         timeout_cnt_q <= timeout_cnt_d;
         loss_cnt_q    <= loss_cnt_d;
      end
   end

   // --------------------------------------------------------------------------
   // Next-state logic.
   // --------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      timeout_evt = 1'b0;
      loss_evt    = 1'b0;

      unique case (state_q)
         ST_PLL_RESET: begin
            if (timer_q == PLL_LAST) begin
               state_d = ST_WAIT_LOCK;
            end
         end
         ST_WAIT_LOCK: begin
            // Lock is tested first so a lock arriving on the timeout cycle wins.
            if (locked_s_q) begin
               state_d = ST_HOLD;
            end else if (timer_q == LOCK_LAST) begin
               state_d     = ST_PLL_RESET;
               timeout_evt = 1'b1;
            end
         end
         ST_HOLD: begin
            if (!locked_s_q) begin
               state_d = ST_WAIT_LOCK;
            end else if (timer_q == HOLD_LAST) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!locked_s_q) begin
               state_d  = ST_PLL_RESET;
               loss_evt = 1'b1;
            end
         end
         default: begin
            state_d = ST_PLL_RESET;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // Timer and counter next values.
   // --------------------------------------------------------------------------
   always_comb begin
      timer_d = timer_q;
      if (state_d != state_q) begin
         timer_d = '0;
      end else if (state_q != ST_RUN) begin
         // RUN has no timed exit, so the timer parks there instead of wrapping.
         timer_d = timer_q + 1'b1;
      end

      timeout_cnt_d = timeout_cnt_q;
      loss_cnt_d    = loss_cnt_q;
      if (clear_counts) begin
         // Clear wins over a same-cycle increment.
         timeout_cnt_d = '0;
         loss_cnt_d    = '0;
      end else begin
         if (timeout_evt && (timeout_cnt_q != CNT_MAX)) begin
            timeout_cnt_d = timeout_cnt_q + 1'b1;
         end
         if (loss_evt && (loss_cnt_q != CNT_MAX)) begin
            loss_cnt_d = loss_cnt_q + 1'b1;
         end
      end
   end

   assign pll_rst         = pll_rst_q;
   assign sys_rst         = sys_rst_q;
   assign ready           = ready_q;
   assign state           = state_q;
   assign timeout_count   = timeout_cnt_q;
   assign lock_loss_count = loss_cnt_q;

endmodule

// File: tb/tb_artemis_rst_sequencer.sv
// -----------------------------------------------------------------------------
// tb_artemis_rst_sequencer
//
// Directed scenarios with hand-derived latencies, followed by a randomized
// run. A behavioural model of the sequencing rules is stepped every clock and
// compared against every DUT output on every falling edge once reset has
// been applied.
// -----------------------------------------------------------------------------
module tb_artemis_rst_sequencer;

   localparam int P  = 4;   // PLL_RST_CYCLES
   localparam int T  = 20;  // LOCK_TIMEOUT
   localparam int H  = 8;   // HOLD_CYCLES
   localparam int CW = 2;   // CNT_WIDTH
   localparam int CMAX = (1 << CW) - 1;

   // ---------------- clock / reset block ----------------
   logic          clk = 1'b0;
   logic          rst;
   logic          pll_locked;
   logic          clear_counts;
   logic          pll_rst, sys_rst, ready;
   logic [1:0]    state;
   logic [CW-1:0] timeout_count, lock_loss_count;

   always #5 clk = ~clk;

   artemis_rst_sequencer #(
      .PLL_RST_CYCLES (P),
      .LOCK_TIMEOUT   (T),
      .HOLD_CYCLES    (H),
      .CNT_WIDTH      (CW)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .pll_locked      (pll_locked),
      .clear_counts    (clear_counts),
      .pll_rst         (pll_rst),
      .sys_rst         (sys_rst),
      .ready           (ready),
      .state           (state),
      .timeout_count   (timeout_count),
      .lock_loss_count (lock_loss_count)
   );

   // ---------------- scoreboard bookkeeping ----------------
   int tests_run = 0;
   int tests_failed = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         if (tests_failed <= 30)
            $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Phase numbers follow the state port encoding; elapsed counts cycles
   // spent in the current phase. Lock history holds the last two sampled
   // pll_locked values; the older one is what the sequencer reacts to.
   int m_phase = 0;
   int m_elapsed = 0;
   int m_tc = 0;
   int m_lc = 0;
   bit m_valid = 1'b0;
   logic m_hist[$];

   always @(posedge clk) begin
      if (rst === 1'b1) begin
         m_phase   = 0;
         m_elapsed = 0;
         m_tc      = 0;
         m_lc      = 0;
         m_valid   = 1'b1;
         m_hist    = '{1'b0, 1'b0};
      end else if (m_valid) begin
         logic seen;
         int   nxt;
         bit   t_ev, l_ev;
         seen = m_hist[0];
         nxt  = m_phase;
         t_ev = 1'b0;
         l_ev = 1'b0;
         if (m_phase == 0) begin
            if (m_elapsed + 1 >= P) nxt = 1;
         end else if (m_phase == 1) begin
            if (seen) nxt = 2;
            else if (m_elapsed + 1 >= T) begin nxt = 0; t_ev = 1'b1; end
         end else if (m_phase == 2) begin
            if (!seen) nxt = 1;
            else if (m_elapsed + 1 >= H) nxt = 3;
         end else begin
            if (!seen) begin nxt = 0; l_ev = 1'b1; end
         end
         m_elapsed = (nxt != m_phase) ? 0 : m_elapsed + 1;
         m_phase   = nxt;
         if (clear_counts) begin
            m_tc = 0;
            m_lc = 0;
         end else begin
            if (t_ev) m_tc = (m_tc < CMAX) ? m_tc + 1 : CMAX;
            if (l_ev) m_lc = (m_lc < CMAX) ? m_lc + 1 : CMAX;
         end
         void'(m_hist.pop_front());
         m_hist.push_back(pll_locked);
      end
   end

   // One compare process: every output, every cycle, on the falling edge.
   always @(negedge clk) begin
      if (m_valid) begin
         check("cyc_state",   state,           m_phase);
         check("cyc_pll_rst", pll_rst,         (m_phase == 0));
         check("cyc_sys_rst", sys_rst,         (m_phase != 3));
         check("cyc_ready",   ready,           (m_phase == 3));
         check("cyc_tcount",  timeout_count,   m_tc);
         check("cyc_lcount",  lock_loss_count, m_lc);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_state(input string name, input logic [1:0] s, input int lim);
      int n;
      n = 0;
      while (state !== s && n < lim) begin
         tick();
         n++;
      end
      if (state !== s) check(name, state, s);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_state"},   state,           0);
      check({tag, "_pll_rst"}, pll_rst,         1);
      check({tag, "_sys_rst"}, sys_rst,         1);
      check({tag, "_ready"},   ready,           0);
      check({tag, "_tcount"},  timeout_count,   0);
      check({tag, "_lcount"},  lock_loss_count, 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      logic prev;
      bit rise;
      rst          = 1'b1;
      pll_locked   = 1'b0;
      clear_counts = 1'b0;
      tick();

      // Scenario 1: PLL pulse width and lock-to-release latency.
      do_reset();
      check_reset_values("s1_reset");
      n = 1;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (pll_rst === 1'b1) n++;
         else break;
      end
      check("s1_pll_rst_width", n, P);
      ticks(2);
      pll_locked = 1'b1;
      n = 0;
      do begin tick(); n++; end while (sys_rst !== 1'b0 && n < 200);
      // 2 synchronizer edges + 1 edge into HOLD + 8 HOLD cycles.
      check("s1_release_latency", n, 11);
      check("s1_ready", ready, 1);
      check("s1_state_run", state, 3);

      // Scenario 3: lock drop while running.
      pll_locked = 1'b0;
      n = 0;
      do begin tick(); n++; end while (sys_rst !== 1'b1 && n < 50);
      check("s3_drop_latency", n, 3);
      check("s3_lcount", lock_loss_count, 1);
      check("s3_state", state, 0);
      check("s3_ready", ready, 0);
      ticks(2);
      pll_locked = 1'b1;
      wait_state("s3_reseq", 2'd3, 200);
      check("s3_reseq_ready", ready, 1);

      // Scenario 5: clear on the same edge as a lock-loss increment.
      check("s5_pre_lcount", lock_loss_count, 1);
      pll_locked = 1'b0;
      ticks(2);
      clear_counts = 1'b1;
      tick();
      clear_counts = 1'b0;
      check("s5_state", state, 0);
      check("s5_lcount", lock_loss_count, 0);
      pll_locked = 1'b1;
      wait_state("s5_reseq", 2'd3, 200);

      // Scenario 4: lock drop inside HOLD.
      do_reset();
      wait_state("s4_hold", 2'd2, 100);
      ticks(3);
      pll_locked = 1'b0;
      ticks(3);
      check("s4_state_wait", state, 1);
      check("s4_tcount", timeout_count, 0);
      check("s4_lcount", lock_loss_count, 0);
      pll_locked = 1'b1;
      wait_state("s4_rehold", 2'd2, 20);
      n = 0;
      do begin tick(); n++; end while (state !== 2'd3 && n < 50);
      check("s4_full_hold", n, H);

      // Scenario 2: lock never rises; re-pulse period and saturation.
      pll_locked = 1'b0;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         prev = pll_rst;
         n = 0;
         do begin
            tick();
            n++;
            rise = (pll_rst === 1'b1) && (prev === 1'b0);
            prev = pll_rst;
         end while (!rise && n < 100);
         check("s2_period", n, P + T);
         check("s2_tcount", timeout_count, (i + 1 < CMAX) ? i + 1 : CMAX);
      end

      // Scenario 6a: reset in the middle of WAIT_LOCK.
      ticks(6);
      check("s6_pre_wait", state, 1);
      do_reset();
      check_reset_values("s6_wait_reset");

      // Scenario 6b: reset in the middle of RUN, with a nonzero loss count.
      pll_locked = 1'b1;
      wait_state("s6_run1", 2'd3, 200);
      pll_locked = 1'b0;
      ticks(4);
      pll_locked = 1'b1;
      wait_state("s6_run2", 2'd3, 200);
      check("s6_pre_lcount", lock_loss_count, 1);
      ticks(3);
      do_reset();
      check_reset_values("s6_run_reset");

      // Randomized run against the model.
      begin
         int remain;
         remain = 0;
         for (int c = 0; c < 4000; c++) begin
            if (remain == 0) begin
               pll_locked = ~pll_locked;
               remain = pll_locked ? $urandom_range(5, 70) : $urandom_range(1, 35);
            end
            remain--;
            clear_counts = ($urandom_range(0, 29) == 0);
            rst          = ($urandom_range(0, 599) == 0);
            tick();
         end
         rst = 1'b0;
         clear_counts = 1'b0;
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
